// File: rtl/regfile_pkg.sv
// Shared definitions for the digit-serial register file: state encoding,
// default geometry and the width helper used by the top and its sequencer.
package regfile_pkg;

    localparam int unsigned RegfileXlen  = 32;
    localparam int unsigned RegfileNregs = 32;
    localparam int unsigned RegfileDigit = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } seq_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_seq_ctrl.sv
// Transfer sequencer: start/busy/done FSM, digit counter and the select and
// write-enable latches captured when a start is accepted in idle.
module serial_seq_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = RegfileNregs,
    parameter int unsigned ND    = RegfileXlen / RegfileDigit,
    localparam int unsigned SelW = clog2_min1(NREGS),
    localparam int unsigned CntW = clog2_min1(ND)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [SelW-1:0] rd_sel_a_i,
    input  logic [SelW-1:0] rd_sel_b_i,
    input  logic [SelW-1:0] wr_sel_i,
    input  logic            wr_en_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [CntW-1:0] cnt_o,
    output logic [SelW-1:0] sel_a_o,
    output logic [SelW-1:0] sel_b_o,
    output logic [SelW-1:0] wr_sel_o,
    output logic            wr_en_o
);

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SelW-1:0] sel_a_q, sel_a_d;
    logic [SelW-1:0] sel_b_q, sel_b_d;
    logic [SelW-1:0] wr_sel_q, wr_sel_d;
    logic            wr_en_q, wr_en_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        wr_sel_d = wr_sel_q;
        wr_en_d  = wr_en_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StShift;
                    cnt_d    = '0;
                    sel_a_d  = rd_sel_a_i;
                    sel_b_d  = rd_sel_b_i;
                    wr_sel_d = wr_sel_i;
                    wr_en_d  = wr_en_i;
                end
            end
            StShift: begin
                // Counter returns to zero on the last digit so idle shows index 0.
                if (cnt_q == CntW'(ND - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            wr_sel_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            wr_sel_q <= wr_sel_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign busy_o   = (state_q == StShift);
    assign done_o   = (state_q == StDone);
    assign cnt_o    = cnt_q;
    assign sel_a_o  = sel_a_q;
    assign sel_b_o  = sel_b_q;
    assign wr_sel_o = wr_sel_q;
    assign wr_en_o  = wr_en_q;

endmodule

// File: rtl/serial_regfile.sv
// Digit-serial register file: two read ports and one write port streamed a
// digit per cycle, least-significant digit first, under a start/busy/done handshake.
module serial_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RegfileXlen,
    parameter int unsigned NREGS    = RegfileNregs,
    parameter int unsigned DIGIT    = RegfileDigit,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ND      = XLEN / DIGIT,
    localparam int unsigned SelW    = clog2_min1(NREGS),
    localparam int unsigned CntW    = clog2_min1(ND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SelW-1:0]  rd_sel_a,
    input  logic [SelW-1:0]  rd_sel_b,
    input  logic [SelW-1:0]  wr_sel,
    input  logic             wr_en,
    input  logic [DIGIT-1:0] wr_data,
    output logic [DIGIT-1:0] rd_a,
    output logic [DIGIT-1:0] rd_b,
    output logic [CntW-1:0]  digit_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DigitSh = $clog2(DIGIT);
    localparam int unsigned OffW    = CntW + DigitSh;
    localparam bit          ZeroEn  = (ZERO_REG != 0);

    if ((XLEN % DIGIT) != 0) begin : g_bad_xlen
        $error("serial_regfile: XLEN must be a multiple of DIGIT");
    end
    if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8)) begin : g_bad_digit
        $error("serial_regfile: DIGIT must be 1, 2, 4 or 8");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("serial_regfile: NREGS must be a power of two, at least 2");
    end

    logic [CntW-1:0] cnt;
    logic [SelW-1:0] sel_a_l, sel_b_l, wr_sel_l;
    logic            wr_en_l;
    logic            busy_w, done_w;
    logic [OffW-1:0] bit_off;
    logic            wr_ok;

    logic [XLEN-1:0] regs_q [NREGS];

    serial_seq_ctrl #(
        .NREGS (NREGS),
        .ND    (ND)
    ) u_ctrl (
        .clk_i      (clk),
        .rst_ni     (rst),
        .start_i    (start),
        .rd_sel_a_i (rd_sel_a),
        .rd_sel_b_i (rd_sel_b),
        .wr_sel_i   (wr_sel),
        .wr_en_i    (wr_en),
        .busy_o     (busy_w),
        .done_o     (done_w),
        .cnt_o      (cnt),
        .sel_a_o    (sel_a_l),
        .sel_b_o    (sel_b_l),
        .wr_sel_o   (wr_sel_l),
        .wr_en_o    (wr_en_l)
    );

    // DIGIT is a power of two, so the bit offset is the digit index shifted up.
    assign bit_off = OffW'(cnt) << DigitSh;
    assign wr_ok   = busy_w && wr_en_l && !(ZeroEn && (wr_sel_l == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_sel_l][bit_off +: DIGIT] <= wr_data;
        end
    end

    // Reads see the pre-write digit: the write lands on the edge ending the cycle.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (busy_w) begin
            if (!(ZeroEn && (sel_a_l == '0))) begin
                rd_a = regs_q[sel_a_l][bit_off +: DIGIT];
            end
            if (!(ZeroEn && (sel_b_l == '0))) begin
                rd_b = regs_q[sel_b_l][bit_off +: DIGIT];
            end
        end
    end

    assign digit_idx = cnt;
    assign busy      = busy_w;
    assign done      = done_w;

endmodule

// File: tb/tb_serial_regfile.sv
// Scoreboard bench: two instances (DIGIT=1 with hardwired r0, DIGIT=4 without);
// drivers queue expected read values, per-instance monitors check on done.
module tb_serial_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s0_start, s0_we, s0_busy, s0_done;
    logic [4:0] s0_sa, s0_sb, s0_ws, s0_idx;
    logic [0:0] s0_wd, s0_ra, s0_rb;

    logic       s1_start, s1_we, s1_busy, s1_done;
    logic [4:0] s1_sa, s1_sb, s1_ws;
    logic [2:0] s1_idx;
    logic [3:0] s1_wd, s1_ra, s1_rb;

    serial_regfile #(.XLEN(32), .NREGS(32), .DIGIT(1), .ZERO_REG(1)) u_d1 (
        .clk(clk), .rst(rst), .start(s0_start), .rd_sel_a(s0_sa), .rd_sel_b(s0_sb),
        .wr_sel(s0_ws), .wr_en(s0_we), .wr_data(s0_wd), .rd_a(s0_ra), .rd_b(s0_rb),
        .digit_idx(s0_idx), .busy(s0_busy), .done(s0_done)
    );

    serial_regfile #(.XLEN(32), .NREGS(32), .DIGIT(4), .ZERO_REG(0)) u_d4 (
        .clk(clk), .rst(rst), .start(s1_start), .rd_sel_a(s1_sa), .rd_sel_b(s1_sb),
        .wr_sel(s1_ws), .wr_en(s1_we), .wr_data(s1_wd), .rd_a(s1_ra), .rd_b(s1_rb),
        .digit_idx(s1_idx), .busy(s1_busy), .done(s1_done)
    );

    int checks = 0;
    int errors = 0;
    int n0 = 0, n1 = 0;
    int dones0 = 0, dones1 = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] val(input int j);
        logic [31:0] v;
        v = 32'(j);
        if (j % 2 == 0) v = v | 32'h8000_0000;
        return v;
    endfunction

    task automatic drive(input int inst, input logic st, input logic [4:0] sa,
                         input logic [4:0] sb, input logic [4:0] ws, input logic we);
        if (inst == 0) begin
            s0_start = st; s0_sa = sa; s0_sb = sb; s0_ws = ws; s0_we = we;
        end else begin
            s1_start = st; s1_sa = sa; s1_sb = sb; s1_ws = ws; s1_we = we;
        end
    endtask

    // One full sequence; with hold=1 start stays high through SHIFT and DONE
    // with different selects, which the DUT must ignore.
    task automatic run_seq(input int inst, input logic [4:0] sa, input logic [4:0] sb,
                           input logic [4:0] ws, input logic we, input logic [31:0] wd,
                           input logic [31:0] ea, input logic [31:0] eb, input bit hold);
        int nd;
        nd = (inst == 0) ? 32 : 8;
        @(negedge clk);
        drive(inst, 1'b1, sa, sb, ws, we);
        if (inst == 0) begin q0.push_back({ea, eb}); n0++; end
        else begin q1.push_back({ea, eb}); n1++; end
        for (int k = 0; k < nd; k++) begin
            @(negedge clk);
            if (hold) drive(inst, 1'b1, ~sa, ~sb, ~ws, ~we);
            else drive(inst, 1'b0, sa, sb, ws, we);
            if (inst == 0) s0_wd = wd[k +: 1];
            else s1_wd = wd[4*k +: 4];
        end
        @(negedge clk);
        chk("done_timing", {31'd0, (inst == 0) ? s0_done : s1_done}, 32'd1);
        @(negedge clk);
        drive(inst, 1'b0, sa, sb, ws, 1'b0);
        if (hold) begin
            @(negedge clk);
            chk("idle_after_hold", {31'd0, (inst == 0) ? s0_busy : s1_busy}, 32'd0);
        end
    endtask

    logic [31:0] acc0_a, acc0_b, acc1_a, acc1_b;
    int cyc0 = 0, cyc1 = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            acc0_a = '0; acc0_b = '0; cyc0 = 0;
        end else begin
            if (s0_busy) begin
                chk("idx0", {27'd0, s0_idx}, 32'(cyc0));
                acc0_a = {s0_ra, acc0_a[31:1]};
                acc0_b = {s0_rb, acc0_b[31:1]};
                cyc0++;
            end
            if (s0_done) begin
                dones0++;
                chk("idle_zero0", {30'd0, s0_ra, s0_rb}, 32'd0);
                if (q0.size() == 0) begin
                    chk("unexpected_done0", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("rd_a0", acc0_a, e[63:32]);
                    chk("rd_b0", acc0_b, e[31:0]);
                    chk("shift_cycles0", 32'(cyc0), 32'd32);
                end
                cyc0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            acc1_a = '0; acc1_b = '0; cyc1 = 0;
        end else begin
            if (s1_busy) begin
                chk("idx1", {29'd0, s1_idx}, 32'(cyc1));
                acc1_a = {s1_ra, acc1_a[31:4]};
                acc1_b = {s1_rb, acc1_b[31:4]};
                cyc1++;
            end
            if (s1_done) begin
                dones1++;
                chk("idle_zero1", {24'd0, s1_ra, s1_rb}, 32'd0);
                if (q1.size() == 0) begin
                    chk("unexpected_done1", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("rd_a1", acc1_a, e[63:32]);
                    chk("rd_b1", acc1_b, e[31:0]);
                    chk("shift_cycles1", 32'(cyc1), 32'd8);
                end
                cyc1 = 0;
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        drive(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        s0_wd = '0;
        s1_wd = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs0", {25'd0, s0_busy, s0_done, s0_ra, s0_rb, s0_idx[2:0]}, 32'd0);
        chk("reset_idx0", {27'd0, s0_idx}, 32'd0);
        chk("reset_outs1", {18'd0, s1_busy, s1_done, s1_ra, s1_rb, s1_idx}, 32'd0);
        rst = 1'b1;

        // Fill r1..r31, then read back on A with B on hardwired r0.
        for (int j = 1; j < 32; j++) run_seq(0, 5'd0, 5'd0, 5'(j), 1'b1, val(j), 0, 0, 0);
        for (int j = 1; j < 32; j++) run_seq(0, 5'(j), 5'd0, 5'd0, 1'b0, 0, val(j), 0, 0);

        // Hardwired r0 drops writes.
        run_seq(0, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 0, 0, 0);
        run_seq(0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0);

        // Read-during-write of the same register returns the old contents.
        run_seq(0, 5'd7, 5'd0, 5'd7, 1'b1, 32'h1234_5678, 32'd7, 0, 0);
        run_seq(0, 5'd7, 5'd7, 5'd7, 1'b1, 32'hCAFE_F00D, 32'h1234_5678, 32'h1234_5678, 0);
        run_seq(0, 5'd7, 5'd0, 5'd0, 1'b0, 0, 32'hCAFE_F00D, 0, 0);

        // Start held high through a read-only sequence with other selects.
        run_seq(0, 5'd5, 5'd6, 5'd9, 1'b0, 0, val(5), val(6), 1);
        run_seq(0, 5'd9, 5'd26, 5'd0, 1'b0, 0, val(9), val(26), 0);

        // DIGIT=4 instance, r0 is an ordinary register here.
        run_seq(1, 5'd0, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 0, 0, 0);
        run_seq(1, 5'd5, 5'd5, 5'd0, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run_seq(1, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 0, 0, 0);
        run_seq(1, 5'd0, 5'd5, 5'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);

        // Abort a write to r3 at digit 10 with reset; no done may follow.
        @(negedge clk);
        drive(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1);
            s0_wd = 1'b1;
        end
        @(negedge clk);
        chk("busy_before_abort", {31'd0, s0_busy}, 32'd1);
        chk("idx_before_abort", {27'd0, s0_idx}, 32'd10);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, s0_busy}, 32'd0);
        chk("abort_done", {31'd0, s0_done}, 32'd0);
        chk("abort_idx", {27'd0, s0_idx}, 32'd0);
        @(negedge clk);
        drive(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 32; j += 2) run_seq(0, 5'(j), 5'(j + 1), 5'd0, 1'b0, 0, 0, 0, 0);
        run_seq(1, 5'd5, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("done_count0", 32'(dones0), 32'(n0));
        chk("done_count1", 32'(dones1), 32'(n1));
        chk("queue_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_regfile.md
Name: serial_regfile

Overview:
Parametrised digit-serial register file for the bit-serial core; the successor to the single-bit RegFile. Width, depth and digit size (bits moved per cycle) are configurable. An internal digit counter and a start/busy/done handshake replace the externally driven bit position. Provides two read ports and one write port, all streamed a digit per cycle, least-significant digit first.

Parameters:
XLEN, 32, register width in bits; must be a multiple of DIGIT.
NREGS, 32, number of registers; power of two, at least 2.
DIGIT, 1, bits transferred per cycle; one of 1, 2, 4, 8.
ZERO_REG, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-low.
start  input  1  request a transfer sequence; sampled in IDLE only.
rd_sel_a  input  log2(NREGS)  port A register select; latched on an accepted start.
rd_sel_b  input  log2(NREGS)  port B register select; latched on an accepted start.
wr_sel  input  log2(NREGS)  write register select; latched on an accepted start.
wr_en  input  1  write enable for the sequence; latched on an accepted start.
wr_data  input  DIGIT  write digit; sampled each SHIFT cycle.
rd_a  output  DIGIT  port A digit for the current digit index.
rd_b  output  DIGIT  port B digit for the current digit index.
digit_idx  output  log2(XLEN/DIGIT) (min 1)  current digit index.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse after the final digit.

Behaviour:
- ND = XLEN/DIGIT is the number of digits per sequence (32 at the defaults, 8 with DIGIT=4).
- States:
  - IDLE: start=1 accepted -> latch selects and wr_en, cnt<=0 -> SHIFT.
  - SHIFT: cnt increments each cycle. At cnt==ND-1 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. A start in DONE is ignored.
- Throughput: one sequence every ND+2 cycles (start cycle, ND shift cycles, done cycle).
- start while busy or in DONE: ignored, no effect on latched selects.
- Reads:
  - rd_a = reg[sel_a_q][cnt*DIGIT +: DIGIT], combinational from latched state; zero latency from digit_idx. Same rule for rd_b.
  - Outputs are 0 in IDLE and DONE.
  - ZERO_REG=1 and select==0: output is 0.
- Writes: in SHIFT with wr_en_q=1, at the clock edge reg[wr_sel_q][cnt*DIGIT +: DIGIT] <= wr_data. When ZERO_REG=1 and wr_sel_q==0 the write is dropped.
- Read/write same register: a read of digit k returns the pre-write value, because digit k is written on the edge that ends that cycle. Each digit is touched once, so the full read value equals the old register contents.
- A and B may select the same register; both return identical digits.
- Reset (rst=0, asynchronous): all registers 0, state IDLE, cnt 0, latched selects 0, wr_en_q 0; busy, done, rd_a, rd_b and digit_idx all 0.
- Reset mid-sequence aborts the sequence immediately, clears all registers, and produces no done pulse.
- Elaboration fails if XLEN % DIGIT != 0 or DIGIT is not in {1,2,4,8}.

Decomposition:
- Shared package regfile_pkg holds:
  - state encoding constants (IDLE=0, SHIFT=1, DONE=2);
  - the width helper function clog2_min1;
  - the default XLEN/NREGS/DIGIT constants shared with the core.
- One natural sub-module, serial_seq_ctrl, owns the FSM, digit counter, busy/done and select latches. The storage array and digit mux/demux stay in the top module.

Test Plan:
1. Reset, then write regs 1..31 with value j (odd j) or 0x80000000|j (even j) at DIGIT=1; read each back on port A with B=0 -> A equals the written value, B equals 0x00000000, done pulses once per sequence, 34 cycles per sequence.
2. DIGIT=4: write 0xDEADBEEF to reg 5, then read A=5, B=5 -> both streams give digits F,E,E,B,D,A,E,D in order, 8 SHIFT cycles.
3. Write 0xFFFFFFFF to reg 0 (ZERO_REG=1), then read reg 0 -> 0x00000000. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
4. Reg 7 holds 0x12345678; one sequence with wr_sel=7, wr_data 0xCAFEF00D and rd_sel_a=7 -> A streams 0x12345678; a following read returns 0xCAFEF00D.
5. Assert start on every cycle during a sequence with different selects -> selects unchanged, no extra done, next sequence begins only from IDLE.
6. Drop rst at digit 10 of a write to reg 3 -> busy=0 immediately, no done; after release, reg 3 and all other registers read 0x00000000.
